// File: rtl/muldiv_unit.sv
// muldiv_unit -- iterative multiply/divide unit with HI/LO registers.
//
// Decodes the R-type funct field for mult/multu/div/divu/mfhi/mflo/mthi/mtlo.
// Multiply is shift-add and divide is restoring, one bit per cycle. The
// latency is fixed: WIDTH RUN cycles, then one FIX cycle that applies sign
// correction and writes HI/LO.
//
// Ports:
//   clk, reset_n          clock (rising edge), asynchronous active-low reset
//   start, funct          issue strobe and function code
//   srca, srcb            operands (srca also carries mthi/mtlo data)
//   result                HI for mfhi, LO for mflo while idle, else 0 (comb)
//   hi, lo                architectural HI/LO registers
//   busy                  multiply/divide in flight
//   stall                 start & busy & recognised funct (comb)
//   done, div0            completion pulse / divide-by-zero flag (with done)
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic             div0
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH - 1);

  localparam logic [5:0] F_MFHI = 6'b010000;
  localparam logic [5:0] F_MTHI = 6'b010001;
  localparam logic [5:0] F_MFLO = 6'b010010;
  localparam logic [5:0] F_MTLO = 6'b010011;

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t           state_reg, state_next;
  logic [CW-1:0]    count_reg;
  logic [WIDTH-1:0] acc_reg;     // product high half / partial remainder
  logic [WIDTH-1:0] q_reg;       // multiplier->product low half / dividend->quotient
  logic [WIDTH-1:0] b_reg;       // |multiplicand| or |divisor|
  logic [WIDTH-1:0] a_raw_reg;   // unmodified dividend, returned on divide by zero
  logic             is_div_reg;
  logic             neg_reg;     // operand signs differed
  logic             rneg_reg;    // dividend was negative
  logic             bzero_reg;
  logic [WIDTH-1:0] hi_reg, lo_reg;

  // Decode: 0110xx are the long ops, 0100xx the HI/LO moves.
  logic is_long, is_move, known, idle, accept, launch;
  assign is_long = (funct[5:2] == 4'b0110);
  assign is_move = (funct[5:2] == 4'b0100);
  assign known   = is_long | is_move;
  assign idle    = (state_reg == IDLE);
  assign accept  = start & idle & known;
  assign launch  = accept & is_long;

  // funct[0]=0 selects the signed variant of mult/div.
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  assign a_neg = ~funct[0] & srca[WIDTH-1];
  assign b_neg = ~funct[0] & srcb[WIDTH-1];
  assign a_mag = a_neg ? -srca : srca;
  assign b_mag = b_neg ? -srcb : srcb;

  // One iteration of either algorithm.
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH-1:0]   div_sub;
  logic               div_ok;
  logic [WIDTH-1:0]   acc_step, q_step;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  always_comb begin
    mul_sum   = {1'b0, acc_reg} + (q_reg[0] ? {1'b0, b_reg} : {(WIDTH+1){1'b0}});
    div_shift = {acc_reg, q_reg[WIDTH-1]};
    div_ok    = (div_shift >= {1'b0, b_reg});
    // When div_ok the true difference is below b_reg, so WIDTH bits suffice.
    div_sub   = div_shift[WIDTH-1:0] - b_reg;
    if (is_div_reg) begin
      acc_step = div_ok ? div_sub : div_shift[WIDTH-1:0];
      q_step   = {q_reg[WIDTH-2:0], div_ok};
    end else begin
      acc_step = mul_sum[WIDTH:1];
      q_step   = {mul_sum[0], q_reg[WIDTH-1:1]};
    end
    prod_fix = neg_reg ? -{acc_reg, q_reg} : {acc_reg, q_reg};
    quo_fix  = neg_reg ? -q_reg : q_reg;
    rem_fix  = rneg_reg ? -acc_reg : acc_reg;
  end

  // Next state and status outputs.
  always_comb begin
    state_next = state_reg;
    busy       = 1'b0;
    done       = 1'b0;
    div0       = 1'b0;
    case (state_reg)
      IDLE: if (launch) state_next = RUN;
      RUN: begin
        busy = 1'b1;
        if (count_reg == '0) state_next = FIX;
      end
      FIX: begin
        busy       = 1'b1;
        done       = 1'b1;
        div0       = is_div_reg & bzero_reg;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg  <= IDLE;
      count_reg  <= '0;
      acc_reg    <= '0;
      q_reg      <= '0;
      b_reg      <= '0;
      a_raw_reg  <= '0;
      is_div_reg <= 1'b0;
      neg_reg    <= 1'b0;
      rneg_reg   <= 1'b0;
      bzero_reg  <= 1'b0;
      hi_reg     <= '0;
      lo_reg     <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (launch) begin
            count_reg  <= CNT_INIT;
            acc_reg    <= '0;
            q_reg      <= a_mag;
            b_reg      <= b_mag;
            a_raw_reg  <= srca;
            is_div_reg <= funct[1];
            neg_reg    <= a_neg ^ b_neg;
            rneg_reg   <= a_neg;
            bzero_reg  <= (srcb == '0);
          end else if (accept && funct == F_MTHI) begin
            hi_reg <= srca;
          end else if (accept && funct == F_MTLO) begin
            lo_reg <= srca;
          end
        end
        RUN: begin
          acc_reg <= acc_step;
          q_reg   <= q_step;
          if (count_reg != '0) count_reg <= count_reg - 1'b1;
        end
        FIX: begin
          if (!is_div_reg) begin
            {hi_reg, lo_reg} <= prod_fix;
          end else if (bzero_reg) begin
            hi_reg <= a_raw_reg;
            lo_reg <= '1;
          end else begin
            hi_reg <= rem_fix;
            lo_reg <= quo_fix;
          end
        end
        default: ;
      endcase
    end
  end

  assign hi     = hi_reg;
  assign lo     = lo_reg;
  assign stall  = start & busy & known;
  assign result = (idle && funct == F_MFHI) ? hi_reg :
                  (idle && funct == F_MFLO) ? lo_reg : '0;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit (WIDTH=32): the stimulus process pushes
// expected HI/LO/div0 for each long op; a monitor pops on every done pulse
// and checks latency, div0 and the HI/LO written at the following edge.
module tb_muldiv_unit;

  localparam logic [5:0] MULT  = 6'b011000;
  localparam logic [5:0] MULTU = 6'b011001;
  localparam logic [5:0] DIV   = 6'b011010;
  localparam logic [5:0] DIVU  = 6'b011011;
  localparam logic [5:0] MFHI  = 6'b010000;
  localparam logic [5:0] MFLO  = 6'b010010;
  localparam logic [5:0] MTHI  = 6'b010001;
  localparam logic [5:0] MTLO  = 6'b010011;
  localparam logic [5:0] ADD   = 6'b100000;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [5:0]  funct = ADD;
  logic [31:0] srca = '0, srcb = '0;
  logic [31:0] result, hi, lo;
  logic        busy, stall, done, div0;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .funct(funct),
    .srca(srca), .srcb(srcb), .result(result), .hi(hi), .lo(lo),
    .busy(busy), .stall(stall), .done(done), .div0(div0)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        d0;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   busy_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: counts busy cycles, checks each completion against the queue.
  initial begin
    busy_cnt = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        busy_cnt = 0;
      end else begin
        if (busy) busy_cnt++;
        if (done) begin
          if (sb.size() == 0) begin
            chk("unexpected_done", {31'b0, done}, 32'd0);
          end else begin
            mon_e = sb.pop_front();
            chk("latency", busy_cnt, 32'd33);
            chk("div0", {31'b0, div0}, {31'b0, mon_e.d0});
            busy_cnt = 0;
            @(posedge clk); #1;
            chk("hi", hi, mon_e.hi);
            chk("lo", lo, mon_e.lo);
            $display("done: hi=%h lo=%h", hi, lo);
          end
        end else if (div0) begin
          chk("div0_without_done", {31'b0, div0}, 32'd0);
        end
      end
    end
  end

  task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; funct = f; srca = a; srcb = b;
    @(posedge clk); #1;
    // Scramble operands to show they were latched.
    start = 1'b0; funct = ADD; srca = $urandom; srcb = $urandom;
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy) begin ok = 1; break; end
    end
    if (!ok) chk("idle_timeout", {31'b0, busy}, 32'd0);
  endtask

  task automatic long_op(input string name, input logic [5:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] ehi,
                         input logic [31:0] elo, input logic ed0);
    exp_t e;
    e.hi = ehi; e.lo = elo; e.d0 = ed0;
    $display("op %s a=%h b=%h expect hi=%h lo=%h div0=%0d", name, a, b, ehi, elo, ed0);
    sb.push_back(e);
    issue(f, a, b);
    wait_idle();
  endtask

  task automatic mid_op(input string name, input logic [5:0] f, input logic exp_stall,
                        input logic [31:0] ohi, input logic [31:0] olo);
    @(negedge clk);
    start = 1'b1; funct = f; srca = 32'hDEAD_BEEF; srcb = 32'h5;
    #1;
    $display("mid-op %s stall=%0d", name, stall);
    chk({name, "_stall"}, {31'b0, stall}, {31'b0, exp_stall});
    @(posedge clk); #1;
    start = 1'b0; funct = ADD;
    chk({name, "_hi_kept"}, hi, ohi);
    chk({name, "_lo_kept"}, lo, olo);
    chk({name, "_busy"}, {31'b0, busy}, 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state.
    #12;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_div0", {31'b0, div0}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    @(negedge clk); reset_n = 1'b1;
    repeat (2) @(negedge clk);

    long_op("multu_max", MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    long_op("mult_-3x7", MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
    long_op("mult_min2", MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 1'b0);
    long_op("div_-7/2", DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);

    // divu 100/7 with blocked requests presented mid-flight.
    begin
      exp_t e;
      e.hi = 32'd2; e.lo = 32'd14; e.d0 = 1'b0;
      $display("op divu_100/7 with mid-op requests");
      sb.push_back(e);
      issue(DIVU, 32'd100, 32'd7);
      repeat (3) @(negedge clk);
      mid_op("mfhi", MFHI, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      mid_op("mtlo", MTLO, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      mid_op("mult", MULT, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      mid_op("add",  ADD,  1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      wait_idle();
    end

    long_op("div_7/-2", DIV, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 1'b0);
    long_op("div_ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0);
    long_op("divu_5/0", DIVU, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b1);
    long_op("div_-7/0", DIV, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1);

    // Moves and reads while idle.
    $display("op mtlo 0x1234");
    issue(MTLO, 32'h1234, 32'h0);
    chk("mtlo_lo", lo, 32'h1234);
    chk("mtlo_busy", {31'b0, busy}, 32'd0);
    $display("op mthi 0xabcd");
    issue(MTHI, 32'hABCD, 32'h0);
    chk("mthi_hi", hi, 32'hABCD);
    chk("mthi_lo_kept", lo, 32'h1234);
    @(negedge clk);
    start = 1'b1; funct = MFLO; #1;
    $display("op mflo result=%h", result);
    chk("mflo_result", result, 32'h1234);
    chk("mflo_stall", {31'b0, stall}, 32'd0);
    funct = MFHI; #1;
    $display("op mfhi result=%h", result);
    chk("mfhi_result", result, 32'hABCD);
    funct = ADD; srca = 32'hFFFF; #1;
    $display("op add (ignored)");
    chk("add_stall", {31'b0, stall}, 32'd0);
    chk("add_result", result, 32'd0);
    @(posedge clk); #1;
    start = 1'b0;
    chk("add_busy", {31'b0, busy}, 32'd0);
    chk("add_hi", hi, 32'hABCD);
    chk("add_lo", lo, 32'h1234);

    // Asynchronous reset in cycle 10 of a divide.
    $display("op div_100/7 aborted by reset");
    issue(DIV, 32'd100, 32'd7);
    repeat (9) @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    chk("arst_busy", {31'b0, busy}, 32'd0);
    chk("arst_hi", hi, 32'd0);
    chk("arst_lo", lo, 32'd0);
    chk("arst_done", {31'b0, done}, 32'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("post_rst_busy", {31'b0, busy}, 32'd0);
    long_op("multu_3x4", MULTU, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
